bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 4-digit seven-segment scan driver and feeds it a packed 4-digit BCD word.
- Output register updates atomically only when a conversion completes, so the scanned display never shows partial results.
- Optional signed mode puts a minus code (4'hA, which the display decodes as segment g only) in the top digit.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 4, number of BCD digits on the output. Must satisfy 10^(DIGITS-1) >= 2^(WIDTH-1) and 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- number  input  WIDTH  binary value to convert.
- signed_mode  input  1  1 = treat number as two's complement; 0 = unsigned.
- start  input  1  request a conversion. Sampled only in IDLE.
- auto_en  input  1  1 = self-start a conversion every time the FSM is in IDLE.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd_out has been updated.
- bcd_out  output  4*DIGITS  packed BCD. Digit 0 is in [3:0]; the most significant digit is in the top nibble.

Behaviour:
- Reset: asynchronous. rst high forces state=IDLE, busy=0, done=0, bcd_out=0, and clears internal registers. This applies at any time, including mid-conversion. No conversion starts until the first edge with rst low.
- Single clock domain. All outputs are registered.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - done=0 except in the cycle after DONE (see DONE).
  - If (start | auto_en) at the edge: capture number and signed_mode, busy<=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - neg = signed_mode & number[WIDTH-1].
  - Magnitude = neg ? (~number + 1) : number, computed WIDTH bits wide.
  - Signed -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) as unsigned, which is correct.
  - Clear the BCD scratch register, set bit counter=0, go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Each cycle, every scratch digit >= 5 gets +3.
  - Then {scratch, mag} shifts left by 1.
  - Counter increments. On the WIDTH-th shift, go to DONE.
- DONE (1 cycle):
  - bcd_out <= result, with the top digit replaced by 4'hA if neg; otherwise the full DIGITS-digit result.
  - done<=1 and busy<=0 on this same edge. Go to IDLE.
  - done stays high for exactly one cycle.
- Latency: start sampled at edge E. bcd_out and done change at edge E+WIDTH+2 (10 for WIDTH=8).
- Back-to-back: start is accepted in the cycle done is high. The minimum conversion period is WIDTH+3 cycles.
- start while busy is ignored, with no queuing. Changes to number or signed_mode while busy do not affect the running conversion.
- Simultaneous start and auto_en is a single conversion.
- Unsigned mode never emits 4'hA. Every output digit is 0..9 except the sign code.
- bcd_out holds its value between conversions, and holds after reset until the first DONE.

Test Plan:
- Reset mid-conversion: start with number=8'd200, assert rst 4 cycles later -> busy=0, done=0, bcd_out=16'h0000 immediately. No done pulse follows.
- Unsigned: signed_mode=0, number=8'd255, pulse start -> done exactly 10 edges after the sampling edge, bcd_out=16'h0255. Then number=0 -> 16'h0000.
- Signed extremes:
  - number=8'h80 -> 16'hA128.
  - number=8'hFF -> 16'hA001.
  - number=8'h7F -> 16'h0127.
  - number=8'h80 with signed_mode=0 -> 16'h0128.
- Handshake:
  - start held high for 3 cycles -> exactly one conversion.
  - start pulsed while busy, with number changed -> ignored, and the original value is output.
  - start in the done cycle -> accepted, next done 11 cycles later.
- auto_en=1 with number stepping 0..255 -> done pulses every 11 cycles. Each bcd_out matches the number sampled at its start edge, and bcd_out only changes on done edges.
- Exhaustive sweep of all 256 values in both modes against a reference model -> zero mismatches, and no digit > 9 except the signed-negative top digit (4'hA).

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// bcd_out is only written when a conversion completes, so a scanned display never shows partial digits.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    number,
    input  logic                signed_mode,
    input  logic                start,
    input  logic                auto_en,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_num;
    logic            r_sgn;
    logic            r_neg;
    logic [WIDTH-1:0] r_mag;
    logic [BW-1:0]   r_bcd;
    logic [CW-1:0]   r_cnt;

    logic            w_neg;
    logic [BW-1:0]   w_adj;

    assign w_neg = r_sgn & r_num[WIDTH-1];

    // Add-3 correction on every digit that would overflow past 9 once doubled.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_sgn   <= 1'b0;
            r_neg   <= 1'b0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start || auto_en) begin
                        r_num   <= number;
                        r_sgn   <= signed_mode;
                        busy    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // The most negative value negates to itself, which read unsigned is the right magnitude.
                    r_neg   <= w_neg;
                    r_mag   <= w_neg ? (~r_num + 1'b1) : r_num;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_bcd <= {w_adj[BW-2:0], r_mag[WIDTH-1]};
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= DONE;
                end
                DONE: begin
                    bcd_out <= r_neg ? {4'hA, r_bcd[BW-5:0]} : r_bcd;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a cycle model predicts accepted starts, queues the
// expected BCD word, and checks busy/done/bcd_out every cycle on the falling edge.
module tb_bin_to_bcd_seq;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 4;
    localparam int LAT    = WIDTH + 2;

    logic        clk;
    logic        rst;
    logic [7:0]  number;
    logic        signed_mode;
    logic        start;
    logic        auto_en;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .number(number), .signed_mode(signed_mode),
        .start(start), .auto_en(auto_en), .busy(busy), .done(done), .bcd_out(bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          t0;
        logic        neg;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    logic [15:0] exp_disp = '0;
    int          last_done = 0;
    int          prev_done = 0;
    logic        auto_phase = 1'b0;
    int          auto_dones = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input logic [7:0] n, input logic sm);
        int   v;
        logic neg;
        neg = sm && n[7];
        v   = neg ? 256 - int'(n) : int'(n);
        ref_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        if (neg) ref_bcd[15:12] = 4'hA;
    endfunction

    // Check DUT state left by the last rising edge, then advance the model for the next one.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            m_cnt    = 0;
            m_done   = 1'b0;
            exp_disp = '0;
        end else begin
            check("busy", busy, m_cnt != 0);
            check("done", done, m_done);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    logic ok;
                    e = sb.pop_front();
                    check("bcd", bcd_out, e.val);
                    check("latency", cyc - e.t0, LAT);
                    ok = 1'b1;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (bcd_out[4*i +: 4] > 4'd9 &&
                            !(i == DIGITS - 1 && bcd_out[4*i +: 4] == 4'hA && e.neg))
                            ok = 1'b0;
                    end
                    check("digits", ok, 1);
                    exp_disp = e.val;
                end
                prev_done = last_done;
                last_done = cyc;
                if (auto_phase) begin
                    if (auto_dones > 0) check("auto_gap", last_done - prev_done, WIDTH + 3);
                    auto_dones++;
                end
            end
            check("hold", bcd_out, exp_disp);

            m_done = (m_cnt == 1);
            if (m_cnt != 0) begin
                m_cnt--;
            end else if (start || auto_en) begin
                sb.push_back('{val: ref_bcd(number, signed_mode), t0: cyc + 1,
                               neg: signed_mode && number[7]});
                m_cnt = LAT;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_cnt == 0 && !done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_cnt == LAT) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic conv(input logic [7:0] n, input logic sm);
        number      = n;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; number = '0; signed_mode = 1'b0; start = 1'b0; auto_en = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 16'h0000);
        rst = 1'b0;
        tick();

        // Reset mid-conversion: outputs clear at once, no done follows.
        number = 8'd200; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_bcd", bcd_out, 16'h0000);
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();

        conv(8'd255, 1'b0); check("u255", bcd_out, 16'h0255);
        conv(8'd0,   1'b0); check("u0",   bcd_out, 16'h0000);
        conv(8'h80,  1'b1); check("s80",  bcd_out, 16'hA128);
        conv(8'hFF,  1'b1); check("sFF",  bcd_out, 16'hA001);
        conv(8'h7F,  1'b1); check("s7F",  bcd_out, 16'h0127);
        conv(8'h80,  1'b0); check("u80",  bcd_out, 16'h0128);

        // start held for three cycles is one conversion
        number = 8'd77; signed_mode = 1'b0; start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_idle();
        check("held3", bcd_out, 16'h0077);

        // start while busy with a new number is ignored
        number = 8'd37; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        number = 8'd99; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        check("busy_ignore", bcd_out, 16'h0037);
        repeat (5) tick();

        // start during the done cycle is accepted
        number = 8'd123; start = 1'b1;
        tick();
        start = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) check("done_timeout", 0, 1);
        end
        number = 8'd42; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        check("b2b_val", bcd_out, 16'h0042);
        check("b2b_gap", last_done - prev_done, WIDTH + 3);

        // auto_en with number stepping through every value
        auto_phase = 1'b1;
        number = 8'd0; signed_mode = 1'b0; auto_en = 1'b1;
        for (int n = 1; n < 256; n++) begin
            wait_accept();
            number = 8'(n);
        end
        wait_accept();
        auto_en = 1'b0;
        wait_idle();
        auto_phase = 1'b0;
        check("auto_count", auto_dones, 256);
        check("auto_last", bcd_out, 16'h0255);

        for (int n = 0; n < 256; n++) conv(8'(n), 1'b0);
        for (int n = 0; n < 256; n++) conv(8'(n), 1'b1);

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
